// File: rtl/rv_mc_sequencer_pkg.sv
// rtl/rv_mc_sequencer_pkg.sv - sequencer state, instruction class and opcode definitions
package rv_mc_sequencer_pkg;

   typedef enum logic [2:0] {
      FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP
   } seq_state_e;

   typedef enum logic [2:0] {
      CL_LOAD, CL_STORE, CL_OP, CL_OP_IMM, CL_BRANCH, CL_LUI, CL_ILLEGAL
   } instr_class_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv_mc_sequencer_if.sv
// rtl/rv_mc_sequencer_if.sv - instruction and data bus handshakes of the sequencer
interface rv_mc_sequencer_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_gnt;
   logic        dmem_rvalid;

   modport master (
      output imem_req, imem_addr, dmem_req, dmem_we,
      input  imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid
   );

   modport slave (
      input  imem_req, imem_addr, dmem_req, dmem_we,
      output imem_gnt, imem_rvalid, imem_rdata, dmem_gnt, dmem_rvalid
   );
endinterface

// File: rtl/rv_mc_sequencer_instr_class.sv
// rtl/rv_mc_sequencer_instr_class.sv - combinational opcode to instruction class map
module rv_mc_sequencer_instr_class
   import rv_mc_sequencer_pkg::*;
(
   input  logic [6:0]   opcode,
   output instr_class_e cls
);

   always_comb begin
      cls = CL_ILLEGAL;
      case (opcode)
         OPC_LOAD:   cls = CL_LOAD;
         OPC_STORE:  cls = CL_STORE;
         OPC_OP:     cls = CL_OP;
         OPC_OP_IMM: cls = CL_OP_IMM;
         OPC_BRANCH: cls = CL_BRANCH;
         OPC_LUI:    cls = CL_LUI;
         default:    cls = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/rv_mc_sequencer.sv
// rtl/rv_mc_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control FSM with bus timeout trap
module rv_mc_sequencer
   import rv_mc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   rv_mc_sequencer_if.master   bus,
   output logic [31:0]         instr_o,
   output logic [31:0]         pc_o,
   input  logic [31:0]         branch_target_i,
   input  logic                alu_zero_i,
   output logic                rf_we_o,
   output logic                retire_o,
   output logic [31:0]         instret_o,
   output logic                halted_o
);

   localparam logic [2:0] S_FETCH  = FETCH;
   localparam logic [2:0] S_IWAIT  = IWAIT;
   localparam logic [2:0] S_DECODE = DECODE;
   localparam logic [2:0] S_EXEC   = EXEC;
   localparam logic [2:0] S_MEM    = MEM;
   localparam logic [2:0] S_MWAIT  = MWAIT;
   localparam logic [2:0] S_WB     = WB;
   localparam logic [2:0] S_TRAP   = TRAP;

   logic [2:0]       state_q, state_d;
   logic [31:0]      pc_q, instr_q, instret_q;
   logic [CNT_W-1:0] cnt_q, cnt_inc;
   instr_class_e     cls;
   logic             timed_out, bus_wait, retire, take_branch;

   rv_mc_sequencer_instr_class u_class (
      .opcode (instr_q[6:0]),
      .cls    (cls)
   );

   assign cnt_inc   = cnt_q + 1'b1;
   // Trap on the cycle the count would reach TIMEOUT, so a stall lasts exactly TIMEOUT cycles.
   assign timed_out = (TIMEOUT != 0) && (cnt_inc == CNT_W'(TIMEOUT));
   assign bus_wait  = (state_q == S_FETCH) || (state_q == S_IWAIT) ||
                      (state_q == S_MEM)   || (state_q == S_MWAIT);

   assign take_branch = (state_q == S_EXEC) && (cls == CL_BRANCH) &&
                        (instr_q[14:12] == 3'b000) && alu_zero_i;

   assign retire = (state_q == S_WB) ||
                   ((state_q == S_EXEC) && (cls == CL_BRANCH)) ||
                   ((state_q == S_MWAIT) && bus.dmem_rvalid && (cls == CL_STORE));

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:  if (bus.imem_gnt) state_d = S_IWAIT;
                   else if (timed_out) state_d = S_TRAP;
         S_IWAIT:  if (bus.imem_rvalid) state_d = S_DECODE;
                   else if (timed_out) state_d = S_TRAP;
         S_DECODE: state_d = (cls == CL_ILLEGAL) ? S_TRAP : S_EXEC;
         S_EXEC: begin
            case (cls)
               CL_LOAD, CL_STORE: state_d = S_MEM;
               CL_BRANCH:         state_d = S_FETCH;
               default:           state_d = S_WB;
            endcase
         end
         S_MEM:    if (bus.dmem_gnt) state_d = S_MWAIT;
                   else if (timed_out) state_d = S_TRAP;
         S_MWAIT:  if (bus.dmem_rvalid) state_d = (cls == CL_STORE) ? S_FETCH : S_WB;
                   else if (timed_out) state_d = S_TRAP;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= INSTR_NOP;
         instret_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)
            cnt_q <= '0;
         else if (bus_wait)
            cnt_q <= cnt_inc;
         if ((state_q == S_IWAIT) && bus.imem_rvalid)
            instr_q <= bus.imem_rdata;
         if (retire) begin
            instret_q <= instret_q + 32'd1;
            pc_q      <= take_branch ? pc_q + branch_target_i : pc_q + 32'd4;
         end
      end
   end

   // Strobes are gated by the reset input so they are low during the reset cycle itself.
   assign bus.imem_req  = rst_ni && (state_q == S_FETCH);
   assign bus.imem_addr = pc_q;
   assign bus.dmem_req  = rst_ni && (state_q == S_MEM);
   assign bus.dmem_we   = rst_ni && (state_q == S_MEM) && (cls == CL_STORE);
   assign rf_we_o       = rst_ni && (state_q == S_WB) && (instr_q[11:7] != 5'd0);
   assign retire_o      = rst_ni && retire;

   assign instr_o   = instr_q;
   assign pc_o      = pc_q;
   assign instret_o = instret_q;
   assign halted_o  = (state_q == S_TRAP);

endmodule

// File: tb/tb_rv_mc_sequencer.sv
// tb/tb_rv_mc_sequencer.sv - self-checking bench for rv_mc_sequencer
module tb_rv_mc_sequencer;
   import rv_mc_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst_n, rst_nb;
   logic [31:0] instr, pc, instret, tgt;
   logic        zero, rf_we, retire, halted;
   logic [31:0] instr_b, pc_b, instret_b;
   logic        rf_we_b, retire_b, halted_b;

   rv_mc_sequencer_if bus ();
   rv_mc_sequencer_if bus_b ();

   rv_mc_sequencer #(.RESET_PC(32'h0), .TIMEOUT(255), .CNT_W(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus),
      .instr_o(instr), .pc_o(pc), .branch_target_i(tgt), .alu_zero_i(zero),
      .rf_we_o(rf_we), .retire_o(retire), .instret_o(instret), .halted_o(halted)
   );

   rv_mc_sequencer #(.RESET_PC(32'h0), .TIMEOUT(0), .CNT_W(8)) dut_b (
      .clk_i(clk), .rst_ni(rst_nb), .bus(bus_b),
      .instr_o(instr_b), .pc_o(pc_b), .branch_target_i(32'h0), .alu_zero_i(1'b0),
      .rf_we_o(rf_we_b), .retire_o(retire_b), .instret_o(instret_b), .halted_o(halted_b)
   );

   assign bus_b.imem_gnt    = 1'b0;
   assign bus_b.imem_rvalid = 1'b0;
   assign bus_b.imem_rdata  = 32'h0;
   assign bus_b.dmem_gnt    = 1'b0;
   assign bus_b.dmem_rvalid = 1'b0;

   int checks = 0;
   int errors = 0;

   // Architectural model state plus the expected strobe vector for the current cycle.
   logic [31:0] pc_m, instr_m, instret_m;
   logic        e_ireq, e_dreq, e_dwe, e_rfwe, e_ret, e_halt;
   bit          e_valid = 1'b0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b required=%b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (e_valid) begin
         chk1("imem_req", bus.imem_req, e_ireq);
         chk1("dmem_req", bus.dmem_req, e_dreq);
         if (e_dreq) chk1("dmem_we", bus.dmem_we, e_dwe);
         chk1("rf_we", rf_we, e_rfwe);
         chk1("retire", retire, e_ret);
         chk1("halted", halted, e_halt);
         chk32("pc", pc, pc_m);
         chk32("imem_addr", bus.imem_addr, pc_m);
         chk32("instr", instr, instr_m);
         chk32("instret", instret, instret_m);
      end
   end

   task automatic noise();
      bus.imem_gnt    = 1'($urandom);
      bus.imem_rvalid = 1'($urandom);
      bus.imem_rdata  = $urandom;
      bus.dmem_gnt    = 1'($urandom);
      bus.dmem_rvalid = 1'($urandom);
   endtask

   task automatic step(input logic ireq, input logic dreq, input logic dwe,
                       input logic rfwe, input logic ret, input logic halt);
      e_ireq = ireq; e_dreq = dreq; e_dwe = dwe;
      e_rfwe = rfwe; e_ret = ret; e_halt = halt;
      e_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      noise();
      rst_n   = 1'b0;
      e_valid = 1'b0;
      #1;
      chk1("rst_imem_req", bus.imem_req, 1'b0);
      chk1("rst_dmem_req", bus.dmem_req, 1'b0);
      chk1("rst_dmem_we", bus.dmem_we, 1'b0);
      chk1("rst_rf_we", rf_we, 1'b0);
      chk1("rst_retire", retire, 1'b0);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      pc_m      = 32'h0;
      instr_m   = INSTR_NOP;
      instret_m = 32'h0;
   endtask

   task automatic trap_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   // Expand one instruction into its cycle-by-cycle bus schedule from the latency rules.
   task automatic run_instr(input logic [31:0] w, input int gd, input int rd,
                            input int dgd, input int drd, input bit abort);
      logic [6:0] opc;
      bit is_br, is_ld, is_st, legal;
      opc   = w[6:0];
      is_br = (opc == 7'b1100011);
      is_ld = (opc == 7'b0000011);
      is_st = (opc == 7'b0100011);
      legal = is_br || is_ld || is_st || (opc == 7'b0110011) ||
              (opc == 7'b0010011) || (opc == 7'b0110111);
      for (int i = 0; i <= gd; i++) begin
         noise();
         bus.imem_gnt = (i == gd);
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      for (int i = 0; i <= rd; i++) begin
         noise();
         bus.imem_rvalid = (i == rd);
         if (i == rd) bus.imem_rdata = w;
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      instr_m = w;
      noise();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (!legal) return;
      noise();
      if (is_br) begin
         step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         pc_m      = (w[14:12] == 3'b000 && zero) ? pc_m + tgt : pc_m + 32'd4;
         instret_m = instret_m + 32'd1;
         return;
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (is_ld || is_st) begin
         for (int i = 0; i <= dgd; i++) begin
            noise();
            bus.dmem_gnt = (i == dgd);
            step(1'b0, 1'b1, is_st, 1'b0, 1'b0, 1'b0);
         end
         if (abort) begin
            noise();
            bus.dmem_rvalid = 1'b0;
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            return;
         end
         for (int i = 0; i <= drd; i++) begin
            noise();
            bus.dmem_rvalid = (i == drd);
            step(1'b0, 1'b0, 1'b0, 1'b0, is_st && (i == drd), 1'b0);
         end
         if (is_st) begin
            pc_m      = pc_m + 32'd4;
            instret_m = instret_m + 32'd1;
            return;
         end
      end
      noise();
      step(1'b0, 1'b0, 1'b0, w[11:7] != 5'd0, 1'b1, 1'b0);
      pc_m      = pc_m + 32'd4;
      instret_m = instret_m + 32'd1;
   endtask

   initial begin
      int c0;
      logic [31:0] base, w;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic [4:0]  rdx;
      logic [6:0]  illegal_opc [3];
      illegal_opc[0] = 7'b0000000;
      illegal_opc[1] = 7'b1101111;
      illegal_opc[2] = 7'b1111111;

      rst_n  = 1'b0;
      rst_nb = 1'b0;
      zero   = 1'b0;
      tgt    = 32'h0;
      noise();
      repeat (2) @(posedge clk);
      #1;
      rst_nb = 1'b1;

      // ADD x3,x1,x2: five cycles, pc 0->4
      do_reset();
      chk32("reset_pc", pc, 32'h0);
      chk32("reset_instr", instr, 32'h0000_0013);
      c0 = cyc;
      run_instr(32'h002081B3, 0, 0, 0, 0, 1'b0);
      chk32("add_cycles", cyc - c0, 32'd5);
      chk32("add_pc", pc, 32'd4);
      chk32("add_instret", instret, 32'd1);

      // BEQ x0,x0,+8 taken then not taken
      do_reset();
      zero = 1'b1; tgt = 32'd8;
      c0 = cyc;
      run_instr(32'h00000463, 0, 0, 0, 0, 1'b0);
      chk32("beq_cycles", cyc - c0, 32'd4);
      chk32("beq_taken_pc", pc, 32'd8);
      do_reset();
      zero = 1'b0;
      run_instr(32'h00000463, 0, 0, 0, 0, 1'b0);
      chk32("beq_not_taken_pc", pc, 32'd4);

      // LW with min latency, then with gnt delayed 3 cycles
      do_reset();
      c0 = cyc;
      run_instr(32'h0000A103, 0, 0, 0, 0, 1'b0);
      chk32("lw_cycles", cyc - c0, 32'd7);
      do_reset();
      run_instr(32'h0000A103, 0, 0, 3, 0, 1'b0);
      chk32("lw_delay_pc", pc, 32'd4);

      // SW x2,0(x1)
      do_reset();
      c0 = cyc;
      run_instr(32'h0020A023, 0, 0, 0, 0, 1'b0);
      chk32("sw_cycles", cyc - c0, 32'd6);
      chk32("sw_instret", instret, 32'd1);

      // Illegal word traps after decode
      do_reset();
      run_instr(32'hFFFFFFFF, 1, 1, 0, 0, 1'b0);
      trap_cycles(6);
      chk1("illegal_halted", halted, 1'b1);
      chk32("illegal_instret", instret, 32'd0);

      // Fetch grant withheld: halt exactly 255 cycles after FETCH entry
      do_reset();
      for (int i = 0; i < 255; i++) begin
         noise();
         bus.imem_gnt = 1'b0;
         step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
      trap_cycles(4);
      chk1("timeout_halted", halted, 1'b1);

      // Reset while in MWAIT, then a stale dmem rvalid in FETCH
      do_reset();
      run_instr(32'h0000A103, 0, 0, 0, 0, 1'b1);
      do_reset();
      noise();
      bus.dmem_rvalid = 1'b1;
      bus.imem_gnt    = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_instr(32'h002081B3, 0, 0, 0, 0, 1'b0);
      chk32("post_abort_pc", pc, 32'd4);

      // Randomized instruction stream
      do_reset();
      for (int n = 0; n < 120; n++) begin
         base = $urandom;
         f3   = 3'($urandom);
         rdx  = ($urandom_range(0, 3) == 0) ? 5'd0 : base[11:7];
         case ($urandom_range(0, 6))
            0: opc = OPC_LOAD;
            1: opc = OPC_STORE;
            2: opc = OPC_OP;
            3: opc = OPC_OP_IMM;
            4: begin opc = OPC_BRANCH; if ($urandom_range(0, 1) == 1) f3 = 3'b000; end
            5: opc = OPC_LUI;
            default: opc = ($urandom_range(0, 7) == 0) ? illegal_opc[$urandom_range(0, 2)] : OPC_OP;
         endcase
         w    = {base[31:15], f3, rdx, opc};
         zero = 1'($urandom);
         tgt  = $urandom;
         run_instr(w, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
         if (opc == illegal_opc[0] || opc == illegal_opc[1] || opc == illegal_opc[2]) begin
            trap_cycles(2);
            do_reset();
         end
      end

      // TIMEOUT=0 instance has never been granted and must still be fetching
      e_valid = 1'b0;
      chk1("no_timeout_halted", halted_b, 1'b0);
      chk1("no_timeout_imem_req", bus_b.imem_req, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rv_mc_sequencer.md
Name: rv_mc_sequencer

Overview:
Multi-cycle control FSM for the rv core. It fetches an instruction over a req/gnt/rvalid instruction bus and latches it into the instruction register that feeds rv_decoder. It then steps the shared datapath through DECODE/EXEC/MEM/WB, owns the PC and the data-bus handshake, and retires one instruction at a time. Bus stalls are bounded by a timeout; illegal opcodes and timeouts halt the core.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
TIMEOUT, 255, max cycles waiting in any bus state before trap; 0 disables the timeout
CNT_W, 8, width of wait counter; TIMEOUT must fit in CNT_W bits

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; synchronous, active-low
imem_req_o  out  1  instruction fetch request
imem_addr_o  out  32  fetch address, equal to pc_o
imem_gnt_i  in  1  fetch request accepted
imem_rvalid_i  in  1  fetch data valid
imem_rdata_i  in  32  fetch data
instr_o  out  32  instruction register, drives decoder instr_i
pc_o  out  32  current PC
branch_target_i  in  32  decoder branch offset
alu_zero_i  in  1  ALU result == 0
dmem_req_o  out  1  data request
dmem_we_o  out  1  1 = store, 0 = load; valid while dmem_req_o
dmem_gnt_i  in  1  data request accepted
dmem_rvalid_i  in  1  data response valid
rf_we_o  out  1  register file write strobe
retire_o  out  1  one-cycle pulse per retired instruction
instret_o  out  32  retired-instruction counter
halted_o  out  1  sticky trap indicator

Behaviour:
- Reset, sampled on clk_i rise with rst_ni=0: state FETCH, pc_o=RESET_PC, instr_o=32'h0000_0013 (NOP), instret_o=0, wait counter=0, halted_o=0. All strobes (imem_req_o, dmem_req_o, dmem_we_o, rf_we_o, retire_o) are 0 during reset. Reset mid-transaction abandons the transaction; no response is awaited.
- Opcode classes (instr_o[6:0]): LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011, LUI 0110111. Any other opcode is ILLEGAL.
- FETCH: imem_req_o=1, held until imem_gnt_i. On gnt go to IWAIT.
- IWAIT: imem_req_o=0. On imem_rvalid_i latch instr_o<=imem_rdata_i and go to DECODE.
- DECODE: single cycle. ILLEGAL goes to TRAP; all other classes go to EXEC.
- EXEC: single cycle.
  - OP, OP_IMM, LUI go to WB.
  - LOAD, STORE go to MEM.
  - BRANCH: if funct3==000 and alu_zero_i, pc<=pc+branch_target_i (32-bit wrap), else pc<=pc+4. Pulse retire_o, go to FETCH.
- MEM: dmem_req_o=1; dmem_we_o=1 for STORE. Held until dmem_gnt_i, then go to MWAIT.
- MWAIT: wait for dmem_rvalid_i. LOAD goes to WB. STORE sets pc+=4, pulses retire_o, goes to FETCH.
- WB: rf_we_o=1 for exactly one cycle, suppressed when instr_o[11:7]==0. Set pc+=4, pulse retire_o, go to FETCH.
- instret_o increments on each retire_o and wraps 2^32-1 to 0.
- Minimum latency with gnt and rvalid each arriving one cycle after request:
  - ALU/LUI: 5 cycles per instruction.
  - BRANCH: 4 cycles.
  - LOAD: 7 cycles.
  - STORE: 6 cycles.
- Wait counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, IWAIT, MEM or MWAIT.
  - When it reaches TIMEOUT (TIMEOUT≠0), go to TRAP.
- TRAP:
  - halted_o=1 and all strobes are 0; pc_o and instr_o are held.
  - Exit only by reset.
- rvalid or gnt inputs in states that do not expect them are ignored.
- A gnt and an rvalid in the same cycle as the request are treated as gnt only; the rvalid is not accepted until the IWAIT/MWAIT state.

Decomposition:
- rv_pkg additions:
  - seq_state_e {FETCH, IWAIT, DECODE, EXEC, MEM, MWAIT, WB, TRAP}.
  - instr_class_e {CL_LOAD, CL_STORE, CL_OP, CL_OP_IMM, CL_BRANCH, CL_LUI, CL_ILLEGAL}.
  - Opcode localparams OPC_LOAD etc.
- Sub-module rv_instr_class: combinational opcode to instr_class_e, reusable by rv_ctrl.

Test Plan:
- ADD x3,x1,x2 (32'h002081B3) at pc 0, gnt/rvalid one cycle after each request -> rf_we_o high in cycle 5 after reset release; pc_o=4, instret_o=1, retire_o a single-cycle pulse.
- BEQ x0,x0,+8 (32'h00000463), branch_target_i=8: with alu_zero_i=1, pc_o goes 0->8; repeat with alu_zero_i=0, pc_o goes 0->4. rf_we_o never asserted.
- LW x2,0(x1) (32'h0000A103) with dmem_gnt_i delayed 3 cycles -> dmem_req_o held for 4 cycles, dmem_we_o=0, rf_we_o one cycle after dmem_rvalid_i, pc_o=4.
- Illegal word 32'hFFFFFFFF -> TRAP after DECODE: halted_o=1 stays set, imem_req_o=0 thereafter, instret_o unchanged.
- imem_gnt_i held low with TIMEOUT=255 -> halted_o rises exactly 255 cycles after FETCH entry. Repeat with TIMEOUT=0 -> never halts.
- Assert rst_ni=0 for one cycle while in MWAIT, then present a stale dmem_rvalid_i -> state FETCH, pc_o=RESET_PC, rf_we_o stays 0, stale rvalid ignored.
